// File: rtl/isa_pkg.sv
// rtl/isa_pkg.sv - opcodes, legal-fn masks, field positions and loader states for the instruction loader
package isa_pkg;

  localparam logic [3:0] OP_ALU_R  = 4'b1100;
  localparam logic [3:0] OP_ALU_I  = 4'b0100;
  localparam logic [3:0] OP_CMP_R  = 4'b1101;
  localparam logic [3:0] OP_CMP_I  = 4'b0101;
  localparam logic [3:0] OP_LOAD   = 4'b0111;
  localparam logic [3:0] OP_STORE  = 4'b0011;
  localparam logic [3:0] OP_BRANCH = 4'b0010;
  localparam logic [3:0] OP_JAL    = 4'b0110;

  // bit n set means fn == n is legal for that opcode
  localparam logic [15:0] MASK_ALU_R  = 16'h07C7;
  localparam logic [15:0] MASK_ALU_I  = 16'h87C7;
  localparam logic [15:0] MASK_CMP    = 16'h9669;
  localparam logic [15:0] MASK_BRANCH = 16'hFF6F;
  localparam logic [15:0] MASK_ZERO   = 16'h0001;

  localparam int OP_LSB  = 28;
  localparam int FN_LSB  = 24;
  localparam int RD_LSB  = 20;
  localparam int RS1_LSB = 16;
  localparam int RS2_LSB = 12;
  localparam int IMM_LSB = 0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } loader_state_t;

  function automatic logic [15:0] legal_fn_mask(input logic [3:0] op);
    case (op)
      OP_ALU_R:                    return MASK_ALU_R;
      OP_ALU_I:                    return MASK_ALU_I;
      OP_CMP_R, OP_CMP_I:          return MASK_CMP;
      OP_BRANCH:                   return MASK_BRANCH;
      OP_LOAD, OP_STORE, OP_JAL:   return MASK_ZERO;
      default:                     return 16'h0000;
    endcase
  endfunction

endpackage

// File: rtl/instr_mem_loader_if.sv
// rtl/instr_mem_loader_if.sv - decoded-field bundle stream between a producer and the loader
interface instr_mem_loader_if;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [3:0]  in_op;
  logic [3:0]  in_fn;
  logic [3:0]  in_rd;
  logic [3:0]  in_rs1;
  logic [3:0]  in_rs2;
  logic [15:0] in_imm;

  modport master (
    output in_valid, in_last, in_op, in_fn, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready
  );

  modport slave (
    input  in_valid, in_last, in_op, in_fn, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready
  );
endinterface

// File: rtl/instr_field_encoder.sv
// rtl/instr_field_encoder.sv - packs fields into a 32-bit instruction word and flags legality
// Legality checking is built only with INSTR_LOADER_LEGAL_CHECK_EN.
module instr_field_encoder
  import isa_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [3:0]  fn,
  input  logic [3:0]  rd,
  input  logic [3:0]  rs1,
  input  logic [3:0]  rs2,
  input  logic [15:0] imm,
  output logic [31:0] word,
  output logic        legal
);

  always_comb begin
    word = '0;
    word[OP_LSB +: 4]  = op;
    word[FN_LSB +: 4]  = fn;
    word[RD_LSB +: 4]  = rd;
    word[RS1_LSB +: 4] = rs1;
    // op[3] selects R-format (rs2, low bits zero) over I-format (imm)
    if (op[3]) begin
      word[RS2_LSB +: 4] = rs2;
    end else begin
      word[IMM_LSB +: 16] = imm;
    end
  end

`ifdef INSTR_LOADER_LEGAL_CHECK_EN
  logic [15:0] fn_mask;
  assign fn_mask = legal_fn_mask(op);
  assign legal   = fn_mask[fn];
`else
  assign legal = 1'b1;
`endif

endmodule

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - streams encoded instructions into instruction memory
// INSTR_LOADER_LEGAL_CHECK_EN enables rejection and counting of illegal op/fn bundles.
module instr_mem_loader
  import isa_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int DEPTH  = 1024
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [ADDR_W-1:0]   base_addr,
  instr_mem_loader_if.slave   in_bus,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [31:0]         mem_wdata,
  output logic                busy,
  output logic                done,
  output logic                overflow,
  output logic [7:0]          err_cnt
);

  localparam int CNT_W = ADDR_W + 1;

  loader_state_t     state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [CNT_W-1:0]  count;
  logic [CNT_W-1:0]  cnt_next;
  logic [31:0]       word;
  logic              legal;
  logic              full;
  logic              accept;
  logic              hit_full;
  logic              session_start;

  instr_field_encoder u_encoder (
    .op    (in_bus.in_op),
    .fn    (in_bus.in_fn),
    .rd    (in_bus.in_rd),
    .rs1   (in_bus.in_rs1),
    .rs2   (in_bus.in_rs2),
    .imm   (in_bus.in_imm),
    .word  (word),
    .legal (legal)
  );

  // Fullness tracks words written, so it is independent of address wrap.
  assign full            = (count == CNT_W'(DEPTH));
  assign cnt_next        = count + CNT_W'(1);
  assign hit_full        = (cnt_next == CNT_W'(DEPTH));
  assign in_bus.in_ready = (state == ST_LOAD) && !full;
  assign accept          = in_bus.in_valid && in_bus.in_ready;
  assign session_start   = (state == ST_IDLE) && start;
  assign busy            = (state != ST_IDLE);
  assign done            = (state == ST_DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (start) state_nxt = ST_LOAD;
      end
      ST_LOAD: begin
        // a final legal write must appear on mem_we before done, a final rejection goes straight to done
        if (accept) begin
          if (legal && (in_bus.in_last || hit_full)) begin
            state_nxt = ST_FLUSH;
          end else if (!legal && in_bus.in_last) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_FLUSH: state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr      <= '0;
      count     <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      overflow  <= 1'b0;
    end else begin
      mem_we <= 1'b0;
      if (session_start) begin
        addr     <= base_addr;
        count    <= '0;
        overflow <= 1'b0;
      end else if (accept && legal) begin
        mem_we    <= 1'b1;
        mem_addr  <= addr;
        mem_wdata <= word;
        addr      <= addr + ADDR_W'(1);
        count     <= cnt_next;
        if (hit_full && !in_bus.in_last) overflow <= 1'b1;
      end
    end
  end

`ifdef INSTR_LOADER_LEGAL_CHECK_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_cnt <= '0;
    end else if (session_start) begin
      err_cnt <= '0;
    end else if (accept && !legal && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end
`else
  assign err_cnt = '0;
`endif

endmodule
